wb_stage: RTL and testbench

Parametrised write-back stage for the MIPS core: a MEM/WB pipeline register with stall and flush control, followed by write-back source selection and load-data alignment with sign or zero extension. It sits between the data-memory stage and the register-file write port, and drives that port directly. It supersedes the single-mux write-back: it adds link-address write-back, sub-word loads, register-0 write suppression and a retired-instruction counter.

---
 rtl/wb_pkg.sv | 32 +++
 rtl/load_align.sv | 49 ++++
 rtl/wb_stage.sv | 96 +++++++++
 tb/tb_wb_stage.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the MIPS write-back stage: source-select codes, load formats
// and the control half of the MEM/WB pipeline register.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_LINK = 2'b10,
    WB_ALT  = 2'b11
  } wb_sel_e;

  typedef enum logic [2:0] {
    LD_W    = 3'b000,
    LD_H    = 3'b001,
    LD_HU   = 3'b010,
    LD_B    = 3'b011,
    LD_BU   = 3'b100,
    LD_WU   = 3'b101,
    LD_D    = 3'b110,
    LD_RSVD = 3'b111
  } load_type_e;

  // Control fields of the MEM/WB register; data fields are sized by the
  // instantiating stage and kept alongside this struct.
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    wb_sel_e    wb_sel;
    load_type_e load_type;
  } mem_wb_ctrl_t;

endpackage

// File: rtl/load_align.sv
// Little-endian load alignment with sign/zero extension. Purely combinational;
// misaligned low offset bits are ignored rather than trapped.
module load_align
  import wb_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int OFF_W  = $clog2(DATA_W/8)
) (
  input  logic [DATA_W-1:0] read_data,
  input  load_type_e        load_type,
  input  logic [OFF_W-1:0]  byte_off,
  output logic [DATA_W-1:0] load_value
);

  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] word_s;
  logic [DATA_W-1:0] word_u;

  assign byte_sel = read_data[{byte_off, 3'b000} +: 8];
  assign half_sel = read_data[{byte_off[OFF_W-1:1], 4'b0000} +: 16];

  // A 32-bit datapath has only one word, so LW, LWU and LD all pass it through.
  generate
    if (DATA_W > 32) begin : g_wide
      logic [31:0] word_sel;
      assign word_sel = read_data[{byte_off[OFF_W-1], 5'b00000} +: 32];
      assign word_s   = {{(DATA_W-32){word_sel[31]}}, word_sel};
      assign word_u   = {{(DATA_W-32){1'b0}}, word_sel};
    end else begin : g_narrow
      assign word_s = read_data;
      assign word_u = read_data;
    end
  endgenerate

  always_comb begin
    load_value = word_s;
    case (load_type)
      LD_B:    load_value = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LD_BU:   load_value = {{(DATA_W-8){1'b0}}, byte_sel};
      LD_H:    load_value = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LD_HU:   load_value = {{(DATA_W-16){1'b0}}, half_sel};
      LD_WU:   load_value = word_u;
      LD_D:    load_value = read_data;
      default: load_value = word_s;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register with stall/flush, write-back source selection,
// register-0 write suppression and a retired-instruction counter.
module wb_stage
  import wb_pkg::*;
#(
  parameter  int DATA_W     = 32,
  parameter  int REG_ADDR_W = 5,
  parameter  int CNT_W      = 32,
  localparam int OFF_W      = $clog2(DATA_W/8)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic                  in_reg_write,
  input  logic [1:0]            in_wb_sel,
  input  logic [2:0]            in_load_type,
  input  logic [OFF_W-1:0]      in_byte_off,
  input  logic [REG_ADDR_W-1:0] in_dest,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [DATA_W-1:0]     in_read_data,
  input  logic [DATA_W-1:0]     in_link_addr,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic [CNT_W-1:0]      retire_count
);

  mem_wb_ctrl_t          ctrl_q;
  logic [OFF_W-1:0]      byte_off_q;
  logic [REG_ADDR_W-1:0] dest_q;
  logic [DATA_W-1:0]     alu_q;
  logic [DATA_W-1:0]     read_q;
  logic [DATA_W-1:0]     link_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_W-1:0]     load_value;

  // Flush only has to kill the valid bit; the other fields are don't-care
  // for a bubble, so they simply hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= '0;
      byte_off_q <= '0;
      dest_q     <= '0;
      alu_q      <= '0;
      read_q     <= '0;
      link_q     <= '0;
    end else if (flush) begin
      ctrl_q.valid <= 1'b0;
    end else if (!stall) begin
      ctrl_q.valid     <= in_valid;
      ctrl_q.reg_write <= in_reg_write;
      ctrl_q.wb_sel    <= wb_sel_e'(in_wb_sel);
      ctrl_q.load_type <= load_type_e'(in_load_type);
      byte_off_q       <= in_byte_off;
      dest_q           <= in_dest;
      alu_q            <= in_alu_result;
      read_q           <= in_read_data;
      link_q           <= in_link_addr;
    end
  end

  // An instruction retires on the edge where it leaves WB, so a stalled slot
  // is counted exactly once, when the stall releases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (ctrl_q.valid && !stall) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  load_align #(
    .DATA_W(DATA_W)
  ) u_load_align (
    .read_data (read_q),
    .load_type (ctrl_q.load_type),
    .byte_off  (byte_off_q),
    .load_value(load_value)
  );

  always_comb begin
    rf_wdata = alu_q;
    case (ctrl_q.wb_sel)
      WB_MEM:  rf_wdata = load_value;
      WB_LINK: rf_wdata = link_q;
      default: rf_wdata = alu_q;
    endcase
  end

  assign rf_we        = ctrl_q.valid & ctrl_q.reg_write & (|dest_q);
  assign rf_waddr     = dest_q;
  assign retire_count = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: a 32-bit instance (4-bit counter) and a 64-bit
// instance share stimulus and are checked every cycle against a behavioural model.
module tb_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic        in_reg_write;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_load_type;
  logic [2:0]  off;
  logic [4:0]  in_dest;
  logic [63:0] alu;
  logic [63:0] rd;
  logic [63:0] link;

  logic        we32;
  logic [4:0]  wa32;
  logic [31:0] wd32;
  logic [3:0]  rc32;
  logic        we64;
  logic [4:0]  wa64;
  logic [63:0] wd64;
  logic [31:0] rc64;

  int n_cmp = 0;
  int n_err = 0;

  wb_stage #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(4)) u32 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel),
    .in_load_type(in_load_type), .in_byte_off(off[1:0]), .in_dest(in_dest),
    .in_alu_result(alu[31:0]), .in_read_data(rd[31:0]), .in_link_addr(link[31:0]),
    .rf_we(we32), .rf_waddr(wa32), .rf_wdata(wd32), .retire_count(rc32)
  );

  wb_stage #(.DATA_W(64), .REG_ADDR_W(5), .CNT_W(32)) u64 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_reg_write(in_reg_write), .in_wb_sel(in_wb_sel),
    .in_load_type(in_load_type), .in_byte_off(off), .in_dest(in_dest),
    .in_alu_result(alu), .in_read_data(rd), .in_link_addr(link),
    .rf_we(we64), .rf_waddr(wa64), .rf_wdata(wd64), .retire_count(rc64)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_valid, m_rw;
  logic [1:0]  m_sel;
  logic [2:0]  m_lt, m_off;
  logic [4:0]  m_dest;
  logic [63:0] m_alu, m_rd, m_link;
  logic [31:0] m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 0; m_rw <= 0; m_sel <= 0; m_lt <= 0; m_off <= 0; m_dest <= 0;
      m_alu <= 0; m_rd <= 0; m_link <= 0; m_cnt <= 0;
    end else begin
      if (m_valid && !stall) m_cnt <= m_cnt + 1;
      if (flush) m_valid <= 1'b0;
      else if (!stall) begin
        m_valid <= in_valid; m_rw <= in_reg_write; m_sel <= in_wb_sel;
        m_lt <= in_load_type; m_off <= off; m_dest <= in_dest;
        m_alu <= alu; m_rd <= rd; m_link <= link;
      end
    end
  end

  function automatic logic [63:0] dw_mask(input int dw);
    return (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] exp_load(input int dw, input logic [2:0] lt,
                                           input logic [2:0] o3, input logic [63:0] data);
    int nb = dw / 8;
    int o = int'(o3) % nb;
    int size;
    int sh;
    bit sgn;
    logic [63:0] v, m, one;
    one = 64'd1;
    case (lt)
      3'd3:    begin size = 8;  sgn = 1; sh = o; end
      3'd4:    begin size = 8;  sgn = 0; sh = o; end
      3'd1:    begin size = 16; sgn = 1; sh = o - (o % 2); end
      3'd2:    begin size = 16; sgn = 0; sh = o - (o % 2); end
      3'd5:    begin size = 32; sgn = 0; sh = (o / 4) * 4; end
      3'd6:    begin size = dw; sgn = 0; sh = 0; end
      default: begin size = 32; sgn = 1; sh = (o / 4) * 4; end
    endcase
    v = (data & dw_mask(dw)) >> (8 * sh);
    if (size < 64) begin
      m = (one << size) - 1;
      v = v & m;
      if (sgn && v[size-1]) v = v | ~m;
    end
    return v & dw_mask(dw);
  endfunction

  function automatic logic [63:0] exp_wdata(input int dw);
    case (m_sel)
      2'd1:    return exp_load(dw, m_lt, m_off, m_rd);
      2'd2:    return m_link & dw_mask(dw);
      default: return m_alu & dw_mask(dw);
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      logic exp_we;
      exp_we = m_valid && m_rw && (m_dest != 0);
      chk("model_we32", 64'(we32), 64'(exp_we));
      chk("model_we64", 64'(we64), 64'(exp_we));
      chk("model_cnt32", 64'(rc32), 64'(m_cnt[3:0]));
      chk("model_cnt64", 64'(rc64), 64'(m_cnt));
      if (exp_we) begin
        chk("model_waddr32", 64'(wa32), 64'(m_dest));
        chk("model_waddr64", 64'(wa64), 64'(m_dest));
        chk("model_wdata32", 64'(wd32), exp_wdata(32));
        chk("model_wdata64", wd64, exp_wdata(64));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic v, input logic rw, input logic [1:0] sel,
                       input logic [2:0] lt, input logic [2:0] o, input logic [4:0] d,
                       input logic [63:0] a, input logic [63:0] r, input logic [63:0] l);
    in_valid = v; in_reg_write = rw; in_wb_sel = sel; in_load_type = lt;
    off = o; in_dest = d; alu = a; rd = r; link = l;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]  lt;
    logic [2:0]  o;
    logic [31:0] exp;
    string       name;
  } load_vec_t;

  load_vec_t lv32[5];
  load_vec_t lv64[3];

  initial begin
    lv32[0] = '{3'd3, 3'd0, 32'hFFFF_FFBB, "lb_off0"};
    lv32[1] = '{3'd4, 3'd3, 32'h0000_0088, "lbu_off3"};
    lv32[2] = '{3'd1, 3'd2, 32'hFFFF_8899, "lh_off2"};
    lv32[3] = '{3'd2, 3'd0, 32'h0000_AABB, "lhu_off0"};
    lv32[4] = '{3'd0, 3'd0, 32'h8899_AABB, "lw"};
    lv64[0] = '{3'd0, 3'd4, 32'h0, "lw64_off4"};
    lv64[1] = '{3'd5, 3'd4, 32'h0, "lwu64_off4"};
    lv64[2] = '{3'd6, 3'd0, 32'h0, "ld64"};

    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(0, 0, 2'd0, 3'd0, 3'd0, 5'd0, 64'h0, 64'h0, 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_we", 64'(we32), 64'd0);
    chk("reset_waddr", 64'(wa32), 64'd0);
    chk("reset_wdata", 64'(wd32), 64'd0);
    chk("reset_cnt", 64'(rc64), 64'd0);

    // single ALU op
    drive(1, 1, 2'd0, 3'd0, 3'd0, 5'd5, 64'h1, 64'h0, 64'h0);
    step();
    chk("alu_we", 64'(we32), 64'd1);
    chk("alu_waddr", 64'(wa32), 64'd5);
    chk("alu_wdata", 64'(wd32), 64'h1);
    drive(0, 0, 2'd0, 3'd0, 3'd0, 5'd0, 64'h0, 64'h0, 64'h0);
    step();
    chk("alu_retired", 64'(rc64), 64'd1);

    // 32-bit load alignment
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 2'd1, lv32[i].lt, lv32[i].o, 5'd7, 64'h0, 64'h0000_0000_8899_AABB, 64'h0);
      step();
      chk(lv32[i].name, 64'(wd32), 64'(lv32[i].exp));
    end

    // 64-bit load alignment
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 2'd1, lv64[i].lt, lv64[i].o, 5'd8, 64'h0, 64'h8000_0001_7FFF_FFFE, 64'h0);
      step();
      case (i)
        0: chk(lv64[i].name, wd64, 64'hFFFF_FFFF_8000_0001);
        1: chk(lv64[i].name, wd64, 64'h0000_0000_8000_0001);
        default: chk(lv64[i].name, wd64, 64'h8000_0001_7FFF_FFFE);
      endcase
    end

    // link write-back, then the same op aimed at register 0
    drive(1, 1, 2'd2, 3'd0, 3'd0, 5'd31, 64'h5, 64'h0, 64'h0040_0008);
    step();
    chk("link_wdata", 64'(wd32), 64'h0040_0008);
    chk("link_waddr", 64'(wa32), 64'd31);
    drive(1, 1, 2'd2, 3'd0, 3'd0, 5'd0, 64'h5, 64'h0, 64'h0040_0008);
    step();
    chk("link_r0_we", 64'(we32), 64'd0);

    // stall for three cycles, release into a new op, then flush+stall
    drive(1, 1, 2'd0, 3'd0, 3'd0, 5'd5, 64'h1234, 64'h0, 64'h0);
    step();
    stall = 1'b1;
    drive(1, 1, 2'd0, 3'd0, 3'd0, 5'd9, 64'hDEAD, 64'h0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_we", 64'(we32), 64'd1);
      chk("stall_waddr", 64'(wa32), 64'd5);
      chk("stall_wdata", 64'(wd32), 64'h1234);
    end
    stall = 1'b0;
    drive(1, 1, 2'd0, 3'd0, 3'd0, 5'd6, 64'h66, 64'h0, 64'h0);
    step();
    stall = 1'b1; flush = 1'b1;
    step();
    chk("flush_stall_we", 64'(we32), 64'd0);
    stall = 1'b0; flush = 1'b0;
    drive(0, 0, 2'd0, 3'd0, 3'd0, 5'd0, 64'h0, 64'h0, 64'h0);
    step();

    // counter wrap on the 4-bit instance
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1, 1, 2'd0, 3'd0, 3'd0, 5'd3, 64'(i), 64'h0, 64'h0);
      step();
    end
    drive(0, 0, 2'd0, 3'd0, 3'd0, 5'd0, 64'h0, 64'h0, 64'h0);
    step();
    chk("wrap_cnt4", 64'(rc32), 64'd1);
    chk("wrap_cnt32", 64'(rc64), 64'd17);

    // asynchronous reset in mid-cycle
    drive(1, 1, 2'd0, 3'd0, 3'd0, 5'd3, 64'h77, 64'h0, 64'h0);
    step();
    chk("pre_reset_we", 64'(we32), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_we32", 64'(we32), 64'd0);
    chk("async_reset_we64", 64'(we64), 64'd0);
    chk("async_reset_cnt32", 64'(rc32), 64'd0);
    chk("async_reset_cnt64", 64'(rc64), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
